mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that sits directly upstream of `mem_fsm` and multiplexes the CPU's data port (load/store) and instruction-fetch port onto its single request interface. It issues one transaction at a time, holds `read_en`/`write_en` with stable address and data until `mem_fsm` raises `done`, and returns read data and a completion pulse to the granted requester. Ties are broken round-robin so neither port starves.

## Interface
Parameters:
- `ADDR_W`, 16, address width for both requesters and the downstream port.
- `DATA_W`, 16, data word width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `d_req`  in  1  data port request; held high until `d_ack`.
- `d_we`  in  1  data port direction: 1 = write, 0 = read; stable while `d_req`.
- `d_addr`  in  ADDR_W  data port address.
- `d_wdata`  in  DATA_W  data port write data.
- `d_rdata`  out  DATA_W  data port read result; valid from the `d_ack` cycle, held until the next data-port read completes.
- `d_ack`  out  1  one-cycle completion pulse for the data port.
- `f_req`  in  1  fetch port request (read-only).
- `f_addr`  in  ADDR_W  fetch address.
- `f_rdata`  out  DATA_W  fetched word; same validity rule as `d_rdata`.
- `f_ack`  out  1  one-cycle completion pulse for the fetch port.
- `m_addr`  out  ADDR_W  to `mem_fsm` `addr`.
- `m_data_in`  out  DATA_W  to `mem_fsm` `data_in`.
- `m_read_en`  out  1  to `mem_fsm` `read_en`.
- `m_write_en`  out  1  to `mem_fsm` `write_en`.
- `m_data_out`  in  DATA_W  from `mem_fsm` `data_out`.
- `m_done`  in  1  from `mem_fsm` `done`.

## Operation
- States: `RELEASE`, `IDLE`, `BUSY`. Reset state is `RELEASE` (`mem_fsm` has no reset; `m_done` may still be high).
- `RELEASE`: enables low; when `m_done == 0` sampled → `IDLE`.
- `IDLE`: if any `*_req` high, choose grant, register `m_addr`, `m_data_in`, enables from the granted port, store `grant` → `BUSY`. Fetch: `m_read_en=1`. Data: `m_write_en=d_we`, `m_read_en=~d_we`. Otherwise stay.
- `BUSY`: `m_*` outputs held constant. On `m_done == 1`: drop both enables, pulse `ack` of granted port, on reads latch `m_data_out` into that port's `rdata`, update `last_grant` → `RELEASE`.
- Arbitration: one requester → grant it. Both → grant the port not equal to `last_grant`. `last_grant` resets to fetch, so data wins the first tie.
- Request inputs are sampled only in `IDLE`; changes to a requester's addr/data after grant do not affect the transaction in flight.
- Requester rule: drop `req` no later than the edge at which it samples `ack=1`. A `req` still high in the following `IDLE` is a new transaction (back-to-back allowed).
- Writes never change `d_rdata`. Never both enables high. Never both acks high.
- Enables, `m_addr`, `m_data_in` never change while in `BUSY`.

## Timing
- Reset (async, any state, including mid-transaction): all outputs 0 immediately (`m_*`, `*_rdata`, `*_ack`), `last_grant` = fetch, state `RELEASE`. A transaction aborted by reset is never acked.
- Launch: `req` sampled in `IDLE` at edge N → enables high after edge N.
- Completion: `m_done` sampled high at edge M → `ack` high and `rdata` valid for cycle M..M+1, enables low after M.
- Minimum gap between launches: one `RELEASE` cycle plus one `IDLE` cycle (`m_done` must be seen low first).
- Latency req→ack = 1 + (mem_fsm latency) cycles; no upper bound imposed (no timeout).

## Structure
- Shared package `mem_bus_pkg`: state encoding (`RELEASE`/`IDLE`/`BUSY`), port-index constants `PORT_DATA=0`, `PORT_FETCH=1`, default `ADDR_W`/`DATA_W`.
- One sub-module `rr_arb2`: combinational two-way round-robin grant from (`req[1:0]`, `last_grant`) → `grant`, `any`. FSM and datapath registers stay in `mem_arbiter`.

## Test plan
- Single fetch: preload mem[0x0010]=0xBEEF, `f_req`, `f_addr=0x0010` → one `f_ack` pulse, `f_rdata=0xBEEF`, `d_ack` never high.
- Single write then read: `d_we=1`, `d_addr=0x0001`, `d_wdata=0x1234` → `d_ack`, mem[1]=0x1234, `d_rdata` unchanged; then read 0x0001 → `d_rdata=0x1234`.
- Tie after reset: both req same cycle (data read 0x0002, fetch 0x0003) → data served first, then fetch; reqs held continuously → grants alternate D,F,D,F over 4 transactions.
- Stability: change `d_addr` to 0xFFFF during `BUSY` → `m_addr` stays 0x0002 until `m_done`; enables drop cycle after `m_done` seen; no relaunch until `m_done` low.
- Reset mid-`BUSY`: assert `rst=0` while `m_read_en=1` → all outputs 0 same cycle, no ack; after release with `m_done` still high, arbiter waits in `RELEASE` until `m_done=0`, then serves pending `f_req`.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus arbiter slice.
// Holds the arbiter state encoding, the requester index constants and the
// default address/data widths used by mem_arbiter and rr_arb2.
package mem_bus_pkg;

  // RELEASE waits for mem_fsm to drop done; IDLE picks a requester; BUSY
  // holds one transaction on the downstream port until done.
  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    IDLE    = 2'd1,
    BUSY    = 2'd2
  } arb_state_e;

  // Requester indices; also the bit positions inside the req vector.
  localparam logic PORT_DATA  = 1'b0;
  localparam logic PORT_FETCH = 1'b1;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int DATA_W_DEFAULT = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   req[1:0]   - request vector, index PORT_DATA / PORT_FETCH
//   last_grant - port that completed the previous transaction
//   grant      - selected port (valid when any = 1)
//   any        - at least one request present
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  // Single requester wins outright; on a tie the port not served last wins.
  always_comb begin
    grant = PORT_DATA;
    any   = |req;
    case (req)
      2'b01:   grant = PORT_DATA;
      2'b10:   grant = PORT_FETCH;
      2'b11:   grant = ~last_grant;
      default: grant = PORT_DATA;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of mem_fsm: multiplexes the CPU data port
// (load/store) and the instruction-fetch port onto one request interface.
// Ports:
//   clk, rst (async, active low)
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack : data requester
//   f_req/f_addr              -> f_rdata/f_ack : fetch requester (read only)
//   m_addr/m_data_in/m_read_en/m_write_en      : toward mem_fsm
//   m_data_out/m_done                          : from mem_fsm
// All outputs are registered. One transaction is in flight at a time and
// the downstream request is held constant until mem_fsm reports done.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_read_en,
  output logic              m_write_en,
  input  logic [DATA_W-1:0] m_data_out,
  input  logic              m_done
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_data_in_q, m_data_in_d;
  logic              m_read_en_q, m_read_en_d;
  logic              m_write_en_q, m_write_en_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              f_ack_q, f_ack_d;

  logic              arb_grant;
  logic              arb_any;

  rr_arb2 u_rr_arb2 (
    .req        ({f_req, d_req}),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  // Next-state and datapath: launch in IDLE, hold in BUSY, retire on done.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    m_addr_d     = m_addr_q;
    m_data_in_d  = m_data_in_q;
    m_read_en_d  = m_read_en_q;
    m_write_en_d = m_write_en_q;
    d_rdata_d    = d_rdata_q;
    f_rdata_d    = f_rdata_q;
    d_ack_d      = 1'b0;
    f_ack_d      = 1'b0;
    case (state_q)
      RELEASE: begin
        // mem_fsm has no reset, so done may linger; never launch over it.
        m_read_en_d  = 1'b0;
        m_write_en_d = 1'b0;
        if (!m_done) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          state_d = BUSY;
          if (arb_grant == PORT_FETCH) begin
            m_addr_d     = f_addr;
            m_data_in_d  = {DATA_W{1'b0}};
            m_read_en_d  = 1'b1;
            m_write_en_d = 1'b0;
          end else begin
            m_addr_d     = d_addr;
            m_data_in_d  = d_wdata;
            m_read_en_d  = ~d_we;
            m_write_en_d = d_we;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (m_done) begin
          m_read_en_d  = 1'b0;
          m_write_en_d = 1'b0;
          last_grant_d = grant_q;
          state_d      = RELEASE;
          if (grant_q == PORT_FETCH) begin
            f_ack_d   = 1'b1;
            f_rdata_d = m_data_out;
          end else begin
            d_ack_d = 1'b1;
            // Writes leave the previous load result visible.
            if (m_read_en_q) begin
              d_rdata_d = m_data_out;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d      = RELEASE;
        m_read_en_d  = 1'b0;
        m_write_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RELEASE;
      last_grant_q <= PORT_FETCH;
      grant_q      <= PORT_DATA;
      m_addr_q     <= {ADDR_W{1'b0}};
      m_data_in_q  <= {DATA_W{1'b0}};
      m_read_en_q  <= 1'b0;
      m_write_en_q <= 1'b0;
      d_rdata_q    <= {DATA_W{1'b0}};
      f_rdata_q    <= {DATA_W{1'b0}};
      d_ack_q      <= 1'b0;
      f_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      m_addr_q     <= m_addr_d;
      m_data_in_q  <= m_data_in_d;
      m_read_en_q  <= m_read_en_d;
      m_write_en_q <= m_write_en_d;
      d_rdata_q    <= d_rdata_d;
      f_rdata_q    <= f_rdata_d;
      d_ack_q      <= d_ack_d;
      f_ack_q      <= f_ack_d;
    end
  end

  assign m_addr     = m_addr_q;
  assign m_data_in  = m_data_in_q;
  assign m_read_en  = m_read_en_q;
  assign m_write_en = m_write_en_q;
  assign d_rdata    = d_rdata_q;
  assign f_rdata    = f_rdata_q;
  assign d_ack      = d_ack_q;
  assign f_ack      = f_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small mem_fsm stand-in
// (fixed latency, done held until the enables drop).
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        d_req, d_we, f_req;
  logic [15:0] d_addr, d_wdata, f_addr;
  logic [15:0] d_rdata, f_rdata;
  logic        d_ack, f_ack;
  logic [15:0] m_addr, m_data_in, m_data_out;
  logic        m_read_en, m_write_en, m_done;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_rdata    (f_rdata),
    .f_ack      (f_ack),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_read_en  (m_read_en),
    .m_write_en (m_write_en),
    .m_data_out (m_data_out),
    .m_done     (m_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [15:0] mem [0:65535];
  logic        done_r = 1'b0;
  logic        done_force = 1'b0;
  logic [15:0] data_out_r = 16'h0000;
  int          lat_cnt = 0;
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [15:0] pre_data = 16'h0000;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (m_read_en || m_write_en) begin
      if (!done_r) begin
        if (lat_cnt == LAT - 1) begin
          done_r  <= 1'b1;
          lat_cnt <= 0;
          if (m_write_en) mem[m_addr] <= m_data_in;
          else            data_out_r  <= mem[m_addr];
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end else begin
      done_r  <= 1'b0;
      lat_cnt <= 0;
    end
  end

  assign m_done     = done_r | done_force;
  assign m_data_out = data_out_r;

  // ---------------- bus monitor ----------------
  logic [15:0] launch_q [$];
  int          d_ack_cnt = 0, f_ack_cnt = 0;
  int          both_en_err = 0, both_ack_err = 0, stable_err = 0;
  logic        prev_en = 1'b0, prev_re = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = 16'h0000, prev_din = 16'h0000;

  always @(negedge clk) begin
    if (m_read_en && m_write_en) both_en_err++;
    if (d_ack && f_ack) both_ack_err++;
    if (d_ack) d_ack_cnt++;
    if (f_ack) f_ack_cnt++;
    if ((m_read_en || m_write_en) && !prev_en) launch_q.push_back(m_addr);
    if ((m_read_en || m_write_en) && prev_en &&
        (m_addr != prev_addr || m_data_in != prev_din ||
         m_read_en != prev_re || m_write_en != prev_we)) stable_err++;
    prev_en   = m_read_en | m_write_en;
    prev_re   = m_read_en;
    prev_we   = m_write_en;
    prev_addr = m_addr;
    prev_din  = m_data_in;
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    pre_addr = a;
    pre_data = v;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [69:0] outs;
    rst = 1'b0;
    d_req = 1'b0; d_we = 1'b0; f_req = 1'b0;
    d_addr = 16'h0000; d_wdata = 16'h0000; f_addr = 16'h0000;
    repeat (2) @(negedge clk);
    outs = {m_addr, m_data_in, d_rdata, f_rdata, m_read_en, m_write_en, d_ack, f_ack, 2'b00};
    vec_cnt++;
    if (outs !== 70'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({m_read_en, m_write_en} !== 2'b00) begin
      err_cnt++;
      $display("FAIL idle_no_req: enables got %b expected 00", {m_read_en, m_write_en});
    end
  endtask

  task automatic test_single_fetch;
    int d0, f0;
    d0 = d_ack_cnt; f0 = f_ack_cnt;
    f_addr = 16'h0010;
    f_req  = 1'b1;
    for (int i = 0; i < 50 && !f_ack; i++) @(negedge clk);
    vec_cnt++;
    if (f_ack !== 1'b1) begin
      err_cnt++;
      $display("FAIL fetch_ack_timeout: f_ack got %b expected 1", f_ack);
    end
    f_req = 1'b0;
    vec_cnt++;
    if (f_rdata !== 16'hBEEF) begin
      err_cnt++;
      $display("FAIL fetch_rdata: got %h expected beef", f_rdata);
    end
    @(negedge clk);
    vec_cnt++;
    if (f_ack !== 1'b0) begin
      err_cnt++;
      $display("FAIL fetch_ack_pulse: f_ack got %b expected 0", f_ack);
    end
    vec_cnt++;
    if ((f_ack_cnt - f0) != 1 || (d_ack_cnt - d0) != 0) begin
      err_cnt++;
      $display("FAIL fetch_ack_counts: f=%0d d=%0d expected f=1 d=0", f_ack_cnt - f0, d_ack_cnt - d0);
    end
  endtask

  task automatic test_write_read;
    d_we = 1'b1; d_addr = 16'h0001; d_wdata = 16'h1234; d_req = 1'b1;
    for (int i = 0; i < 50 && !d_ack; i++) @(negedge clk);
    vec_cnt++;
    if (d_ack !== 1'b1) begin
      err_cnt++;
      $display("FAIL write_ack_timeout: d_ack got %b expected 1", d_ack);
    end
    d_req = 1'b0;
    vec_cnt++;
    if (d_rdata !== 16'h0000) begin
      err_cnt++;
      $display("FAIL write_keeps_rdata: got %h expected 0000", d_rdata);
    end
    vec_cnt++;
    if (mem[1] !== 16'h1234) begin
      err_cnt++;
      $display("FAIL write_mem: mem[1] got %h expected 1234", mem[1]);
    end
    @(negedge clk);
    d_we = 1'b0; d_req = 1'b1;
    for (int i = 0; i < 50 && !d_ack; i++) @(negedge clk);
    vec_cnt++;
    if (d_ack !== 1'b1) begin
      err_cnt++;
      $display("FAIL read_ack_timeout: d_ack got %b expected 1", d_ack);
    end
    d_req = 1'b0;
    vec_cnt++;
    if (d_rdata !== 16'h1234) begin
      err_cnt++;
      $display("FAIL read_rdata: got %h expected 1234", d_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_order [4];
    int n;
    exp_order[0] = 16'h0002; exp_order[1] = 16'h0003;
    exp_order[2] = 16'h0002; exp_order[3] = 16'h0003;
    // fresh reset so last_grant is fetch again
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    launch_q.delete();
    d_we = 1'b0; d_addr = 16'h0002; f_addr = 16'h0003;
    d_req = 1'b1; f_req = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (d_ack || f_ack) n++;
    end
    d_req = 1'b0; f_req = 1'b0;
    vec_cnt++;
    if (n != 4) begin
      err_cnt++;
      $display("FAIL tie_ack_timeout: acks got %0d expected 4", n);
    end
    vec_cnt++;
    if (launch_q.size() < 4) begin
      err_cnt++;
      $display("FAIL tie_launch_count: got %0d expected 4", launch_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vec_cnt++;
        if (launch_q[k] !== exp_order[k]) begin
          err_cnt++;
          $display("FAIL tie_order[%0d]: m_addr got %h expected %h", k, launch_q[k], exp_order[k]);
        end
      end
    end
    vec_cnt++;
    if (d_rdata !== 16'hAAAA || f_rdata !== 16'h3333) begin
      err_cnt++;
      $display("FAIL tie_rdata: d=%h f=%h expected d=aaaa f=3333", d_rdata, f_rdata);
    end
  endtask

  task automatic test_stability;
    d_we = 1'b0; d_addr = 16'h0002; d_req = 1'b1;
    for (int i = 0; i < 50 && !m_read_en; i++) @(negedge clk);
    vec_cnt++;
    if (m_read_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL stab_launch_timeout: m_read_en got %b expected 1", m_read_en);
    end
    d_addr = 16'hFFFF;
    for (int i = 0; i < 50 && !m_done; i++) begin
      vec_cnt++;
      if (m_addr !== 16'h0002) begin
        err_cnt++;
        $display("FAIL stab_addr: m_addr got %h expected 0002", m_addr);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (m_done !== 1'b1 || m_read_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL stab_done_seen: done=%b re=%b expected 1 1", m_done, m_read_en);
    end
    done_force = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (m_read_en !== 1'b0 || d_ack !== 1'b1 || d_rdata !== 16'hAAAA) begin
      err_cnt++;
      $display("FAIL stab_retire: re=%b ack=%b rdata=%h expected 0 1 aaaa", m_read_en, d_ack, d_rdata);
    end
    // d_req stays high: a new transaction, but done is still high
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec_cnt++;
      if (m_read_en !== 1'b0) begin
        err_cnt++;
        $display("FAIL stab_no_relaunch: m_read_en got %b expected 0", m_read_en);
      end
    end
    done_force = 1'b0;
    for (int i = 0; i < 50 && !d_ack; i++) @(negedge clk);
    d_req = 1'b0;
    vec_cnt++;
    if (d_ack !== 1'b1 || d_rdata !== 16'h5A5A) begin
      err_cnt++;
      $display("FAIL stab_second_read: ack=%b rdata=%h expected 1 5a5a", d_ack, d_rdata);
    end
  endtask

  task automatic test_reset_mid_busy;
    logic [69:0] outs;
    int f0;
    @(negedge clk);
    f_addr = 16'h0010; f_req = 1'b1;
    for (int i = 0; i < 50 && !m_read_en; i++) @(negedge clk);
    vec_cnt++;
    if (m_read_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL rstmid_launch_timeout: m_read_en got %b expected 1", m_read_en);
    end
    f0 = f_ack_cnt;
    rst = 1'b0;
    done_force = 1'b1;
    #1;
    outs = {m_addr, m_data_in, d_rdata, f_rdata, m_read_en, m_write_en, d_ack, f_ack, 2'b00};
    vec_cnt++;
    if (outs !== 70'd0) begin
      err_cnt++;
      $display("FAIL rstmid_outputs: got %h expected 0", outs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec_cnt++;
      if ({m_read_en, m_write_en, f_ack} !== 3'b000) begin
        err_cnt++;
        $display("FAIL rstmid_wait_release: re/we/ack got %b expected 000", {m_read_en, m_write_en, f_ack});
      end
    end
    done_force = 1'b0;
    for (int i = 0; i < 50 && !f_ack; i++) @(negedge clk);
    f_req = 1'b0;
    vec_cnt++;
    if (f_ack !== 1'b1 || f_rdata !== 16'hBEEF) begin
      err_cnt++;
      $display("FAIL rstmid_serve: ack=%b rdata=%h expected 1 beef", f_ack, f_rdata);
    end
    @(negedge clk);
    vec_cnt++;
    if ((f_ack_cnt - f0) != 1) begin
      err_cnt++;
      $display("FAIL rstmid_ack_count: got %0d expected 1", f_ack_cnt - f0);
    end
  endtask

  task automatic test_protocol;
    vec_cnt++;
    if (both_en_err != 0 || both_ack_err != 0 || stable_err != 0) begin
      err_cnt++;
      $display("FAIL protocol: both_en=%0d both_ack=%0d unstable=%0d expected 0 0 0",
               both_en_err, both_ack_err, stable_err);
    end
  endtask

  initial begin
    test_reset();
    preload(16'h0010, 16'hBEEF);
    preload(16'h0002, 16'hAAAA);
    preload(16'h0003, 16'h3333);
    preload(16'hFFFF, 16'h5A5A);
    test_single_fetch();
    test_write_read();
    test_back_to_back();
    test_stability();
    test_reset_mid_busy();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
